// File: rtl/shift_pkg.sv
// Shared types and helpers for the serial deframer.
// FSM encodings, direction names, counter width helper.
package shift_pkg;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    DATA     = 2'd1,
    SYNC_CHK = 2'd2
  } state_t;

  localparam string DIR_LEFT  = "LEFT";
  localparam string DIR_RIGHT = "RIGHT";

  // Bits needed to hold values 0..n-1, at least 1.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/shift_deframer_sipo.sv
// Serial-in window register with a saturating bit count.
// Direction chooses which end the newest bit enters.
module shift_deframer_sipo
  import shift_pkg::*;
#(
  parameter int    W   = 4,
  parameter string DIR = "LEFT",
  parameter int    CW  = 3
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          sclr,
  input  logic          en,
  input  logic          shiftin,
  input  logic          cnt_clr,
  output logic [W-1:0]  nxt,
  output logic [CW-1:0] bit_cnt
);

  localparam bit IS_RIGHT = (DIR == DIR_RIGHT);
  localparam logic [CW-1:0] FULL = CW'(W);

  logic [W-1:0] window;

  // Window value after shifting in the current bit.
  if (IS_RIGHT) begin : g_right
    assign nxt = {shiftin, window[W-1:1]};
  end else begin : g_left
    assign nxt = {window[W-2:0], shiftin};
  end

  // Shift on en; count bits since last clear, saturating.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      window  <= '0;
      bit_cnt <= '0;
    end else if (sclr) begin
      window  <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      window <= nxt;
      if (cnt_clr)
        bit_cnt <= '0;
      else if (bit_cnt != FULL)
        bit_cnt <= bit_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shift_deframer.sv
// Serial deframer: hunts sync, assembles data words, rechecks sync.
// SHIFT_DEFRAMER_STATS_EN adds frame_cnt/slip_cnt outputs.
module shift_deframer
  import shift_pkg::*;
#(
  parameter int    SHIFT_WIDTH     = 4,
  parameter string SHIFT_DIRECTION = "LEFT",
  parameter logic [SHIFT_WIDTH-1:0] SYNC_VALUE =
    SHIFT_WIDTH'(11),
  parameter int    FRAME_WORDS     = 2
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   sclr,
  input  logic                   en,
  input  logic                   shiftin,
  input  logic                   out_ready,
  output logic [SHIFT_WIDTH-1:0] q,
  output logic                   q_valid,
  output logic                   locked,
  output logic                   overrun
`ifdef SHIFT_DEFRAMER_STATS_EN
  ,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            slip_cnt
`endif
);

  localparam int W   = SHIFT_WIDTH;
  localparam int BW  = clog2(W + 1);
  localparam int WCW = clog2(FRAME_WORDS + 1);
  localparam logic [BW-1:0]  LAST    = BW'(W - 1);
  localparam logic [WCW-1:0] FW_LAST = WCW'(FRAME_WORDS - 1);

  state_t         state, state_n;
  logic [WCW-1:0] word_cnt, word_cnt_n;
  logic [W-1:0]   nxt;
  logic [BW-1:0]  bit_cnt;
  logic           cnt_clr;
  logic           bit_last;
  logic           sync_hit;
  logic           wr;

  shift_deframer_sipo #(
    .W   (W),
    .DIR (SHIFT_DIRECTION),
    .CW  (BW)
  ) u_sipo (
    .clk     (clk),
    .aclr    (aclr),
    .sclr    (sclr),
    .en      (en),
    .shiftin (shiftin),
    .cnt_clr (cnt_clr),
    .nxt     (nxt),
    .bit_cnt (bit_cnt)
  );

  assign bit_last = en && (bit_cnt == LAST);
  assign sync_hit = (nxt == SYNC_VALUE);
  assign wr       = (state == DATA) && bit_last;

  // Next-state decode and bit-count restarts.
  always_comb begin
    state_n    = state;
    word_cnt_n = word_cnt;
    cnt_clr    = 1'b0;
    unique case (state)
      HUNT: begin
        if (en && bit_cnt >= LAST && sync_hit) begin
          state_n    = DATA;
          word_cnt_n = '0;
          cnt_clr    = 1'b1;
        end
      end
      DATA: begin
        if (bit_last) begin
          cnt_clr    = 1'b1;
          word_cnt_n = word_cnt + WCW'(1);
          if (word_cnt == FW_LAST)
            state_n = SYNC_CHK;
        end
      end
      SYNC_CHK: begin
        if (bit_last) begin
          cnt_clr = 1'b1;
          if (sync_hit) begin
            state_n    = DATA;
            word_cnt_n = '0;
          end else begin
            state_n = HUNT;
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // State, word count and registered lock flag.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state    <= HUNT;
      word_cnt <= '0;
      locked   <= 1'b0;
    end else if (sclr) begin
      state    <= HUNT;
      word_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      state    <= state_n;
      word_cnt <= word_cnt_n;
      locked   <= (state_n != HUNT);
    end
  end

  // Output word register with valid/ready and sticky overrun.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (sclr) begin
      q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (wr) begin
      if (!q_valid || out_ready) begin
        q       <= nxt;
        q_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (q_valid && out_ready) begin
      q_valid <= 1'b0;
    end
  end

`ifdef SHIFT_DEFRAMER_STATS_EN
  // Count passed sync checks and slips.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      frame_cnt <= '0;
      slip_cnt  <= '0;
    end else if (sclr) begin
      frame_cnt <= '0;
      slip_cnt  <= '0;
    end else if (state == SYNC_CHK && bit_last) begin
      if (sync_hit)
        frame_cnt <= frame_cnt + 16'd1;
      else
        slip_cnt <= slip_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_deframer.sv
// Bench for shift_deframer: directed table, RIGHT sequence,
// random stream against a bit-queue reference model.
module tb_shift_deframer;

  logic       clk = 1'b0;
  logic       aclr, sclr, en, shiftin, out_ready;
  logic [3:0] q_l, q_r;
  logic       qv_l, qv_r, lk_l, lk_r, ov_l, ov_r;
`ifdef SHIFT_DEFRAMER_STATS_EN
  logic [15:0] fc_l, sc_l, fc_r, sc_r;
`endif

  shift_deframer #(
    .SHIFT_WIDTH(4), .SHIFT_DIRECTION("LEFT"),
    .SYNC_VALUE(4'd11), .FRAME_WORDS(2)
  ) dut_l (
    .clk(clk), .aclr(aclr), .sclr(sclr), .en(en),
    .shiftin(shiftin), .out_ready(out_ready),
    .q(q_l), .q_valid(qv_l), .locked(lk_l),
    .overrun(ov_l)
`ifdef SHIFT_DEFRAMER_STATS_EN
    , .frame_cnt(fc_l), .slip_cnt(sc_l)
`endif
  );

  shift_deframer #(
    .SHIFT_WIDTH(4), .SHIFT_DIRECTION("RIGHT"),
    .SYNC_VALUE(4'd11), .FRAME_WORDS(2)
  ) dut_r (
    .clk(clk), .aclr(aclr), .sclr(sclr), .en(en),
    .shiftin(shiftin), .out_ready(out_ready),
    .q(q_r), .q_valid(qv_r), .locked(lk_r),
    .overrun(ov_r)
`ifdef SHIFT_DEFRAMER_STATS_EN
    , .frame_cnt(fc_r), .slip_cnt(sc_r)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reference model (LEFT, W=4, sync 11, 2 words/frame)
  localparam int MW    = 4;
  localparam int MSYNC = 11;
  localparam int MFW   = 2;

  int          m_mode;  // 0 hunting, 1 data, 2 checking
  int          m_hist[$];
  int          m_words;
  logic [3:0]  m_q;
  bit          m_qv, m_ov;
  logic [15:0] m_frames, m_slips;

  function automatic int hist_val();
    int v = 0;
    foreach (m_hist[i]) v = v * 2 + m_hist[i];
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_hist.delete();
    m_words = 0;
    m_q = '0;
    m_qv = 0;
    m_ov = 0;
    m_frames = '0;
    m_slips = '0;
  endtask

  task automatic model_clock(input bit e, input bit b,
                             input bit r, input bit s);
    bit dlv;
    int v;
    dlv = 0;
    v = 0;
    if (s) begin
      model_reset();
      return;
    end
    if (e) begin
      m_hist.push_back(int'(b));
      if (m_mode == 0) begin
        if (m_hist.size() > MW) void'(m_hist.pop_front());
        if (m_hist.size() == MW && hist_val() == MSYNC) begin
          m_mode = 1;
          m_words = 0;
          m_hist.delete();
        end
      end else if (m_hist.size() == MW) begin
        v = hist_val();
        m_hist.delete();
        if (m_mode == 1) begin
          dlv = 1;
          m_words++;
          if (m_words == MFW) m_mode = 2;
        end else if (v == MSYNC) begin
          m_frames++;
          m_mode = 1;
          m_words = 0;
        end else begin
          m_slips++;
          m_mode = 0;
        end
      end
    end
    if (dlv) begin
      if (!m_qv || r) begin
        m_q = v[3:0];
        m_qv = 1;
      end else begin
        m_ov = 1;
      end
    end else if (m_qv && r) begin
      m_qv = 0;
    end
  endtask

  task automatic step(input bit e, input bit b,
                      input bit r, input bit s);
    en = e;
    shiftin = b;
    out_ready = r;
    sclr = s;
    @(posedge clk);
    model_clock(e, b, r, s);
    @(negedge clk);
  endtask

  task automatic check_model(input int k);
    check($sformatf("rnd%0d q", k), q_l, m_q);
    check($sformatf("rnd%0d q_valid", k), qv_l, m_qv);
    check($sformatf("rnd%0d locked", k), lk_l, m_mode != 0);
    check($sformatf("rnd%0d overrun", k), ov_l, m_ov);
`ifdef SHIFT_DEFRAMER_STATS_EN
    check($sformatf("rnd%0d frame_cnt", k), fc_l, m_frames);
    check($sformatf("rnd%0d slip_cnt", k), sc_l, m_slips);
`endif
  endtask

  task automatic do_aclr(input int tag);
    aclr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      en = 1'($urandom);
      shiftin = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("aclr%0d q", tag), q_l, 4'h0);
      check($sformatf("aclr%0d q_valid", tag), qv_l, 0);
      check($sformatf("aclr%0d locked", tag), lk_l, 0);
      check($sformatf("aclr%0d overrun", tag), ov_l, 0);
      check($sformatf("aclr%0d q_r", tag), q_r, 4'h0);
      check($sformatf("aclr%0d locked_r", tag), lk_r, 0);
    end
    aclr = 1'b0;
    en = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit e, b, r, s;
    logic [3:0] q;
    bit v, l, o;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit e, input bit b,
                     input bit r, input bit s,
                     input logic [3:0] q,
                     input bit v, input bit l,
                     input bit o);
    vec_t t;
    t.e = e; t.b = b; t.r = r; t.s = s;
    t.q = q; t.v = v; t.l = l; t.o = o;
    tbl.push_back(t);
  endtask

  int stream[$];

  initial begin
    aclr = 0; sclr = 0; en = 0;
    shiftin = 0; out_ready = 1;

    // hunt: 0,0,1,0,1,1
    add(1,0,1,0, 4'h0,0,0,0);
    add(1,0,1,0, 4'h0,0,0,0);
    add(1,1,1,0, 4'h0,0,0,0);
    add(1,0,1,0, 4'h0,0,0,0);
    add(1,1,1,0, 4'h0,0,0,0);
    add(1,1,1,0, 4'h0,0,1,0);
    // data 1,(gap),1,0,0 -> C ; 0,1,0,1 -> 5
    add(1,1,1,0, 4'h0,0,1,0);
    add(0,0,1,0, 4'h0,0,1,0);
    add(1,1,1,0, 4'h0,0,1,0);
    add(1,0,1,0, 4'h0,0,1,0);
    add(1,0,1,0, 4'hC,1,1,0);
    add(1,0,1,0, 4'hC,0,1,0);
    add(1,1,1,0, 4'hC,0,1,0);
    add(1,0,1,0, 4'hC,0,1,0);
    add(1,1,1,0, 4'h5,1,1,0);
    // sync check 1,0,1,1 passes
    add(1,1,1,0, 4'h5,0,1,0);
    add(1,0,1,0, 4'h5,0,1,0);
    add(1,1,1,0, 4'h5,0,1,0);
    add(1,1,1,0, 4'h5,0,1,0);
    // data 3, 9
    add(1,0,1,0, 4'h5,0,1,0);
    add(1,0,1,0, 4'h5,0,1,0);
    add(1,1,1,0, 4'h5,0,1,0);
    add(1,1,1,0, 4'h3,1,1,0);
    add(1,1,1,0, 4'h3,0,1,0);
    add(1,0,1,0, 4'h3,0,1,0);
    add(1,0,1,0, 4'h3,0,1,0);
    add(1,1,1,0, 4'h9,1,1,0);
    // sync check 1,1,1,1 fails
    add(1,1,1,0, 4'h9,0,1,0);
    add(1,1,1,0, 4'h9,0,1,0);
    add(1,1,1,0, 4'h9,0,1,0);
    add(1,1,1,0, 4'h9,0,0,0);
    // relock, then stall consumer across two words
    add(1,1,1,0, 4'h9,0,0,0);
    add(1,0,1,0, 4'h9,0,0,0);
    add(1,1,1,0, 4'h9,0,0,0);
    add(1,1,1,0, 4'h9,0,1,0);
    add(1,1,0,0, 4'h9,0,1,0);
    add(1,1,0,0, 4'h9,0,1,0);
    add(1,0,0,0, 4'h9,0,1,0);
    add(1,0,0,0, 4'hC,1,1,0);
    add(1,0,0,0, 4'hC,1,1,0);
    add(1,1,0,0, 4'hC,1,1,0);
    add(1,0,0,0, 4'hC,1,1,0);
    add(1,1,0,0, 4'hC,1,1,1);
    // sclr wins over en
    add(1,1,0,1, 4'h0,0,0,0);

    @(negedge clk);
    do_aclr(0);

    foreach (tbl[i]) begin
      step(tbl[i].e, tbl[i].b, tbl[i].r, tbl[i].s);
      check($sformatf("vec%0d q", i), q_l, tbl[i].q);
      check($sformatf("vec%0d q_valid", i), qv_l, tbl[i].v);
      check($sformatf("vec%0d locked", i), lk_l, tbl[i].l);
      check($sformatf("vec%0d overrun", i), ov_l, tbl[i].o);
    end

    // RIGHT: 1,1,0,1 with gaps -> lock; 0,0,1,1 -> C
    do_aclr(1);
    step(1,1,1,0);
    step(0,0,1,0);
    step(1,1,1,0);
    step(0,1,1,0);
    step(1,0,1,0);
    check("right pre-lock", lk_r, 0);
    step(1,1,1,0);
    check("right locked", lk_r, 1);
    check("right q_valid idle", qv_r, 0);
    step(1,0,1,0);
    step(1,0,1,0);
    step(1,1,1,0);
    check("right q_valid early", qv_r, 0);
    step(1,1,1,0);
    check("right q", q_r, 4'hC);
    check("right q_valid", qv_r, 1);

    // Random stream against the model
    do_aclr(2);
    for (int k = 0; k < 3000; k++) begin
      bit e, b, r, s;
      if (stream.size() == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          stream.push_back(1); stream.push_back(0);
          stream.push_back(1); stream.push_back(1);
        end else begin
          for (int j = 0; j < 4; j++)
            stream.push_back(int'($urandom_range(0, 1)));
        end
      end
      e = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      s = ($urandom_range(0, 199) == 0);
      b = e ? 1'(stream.pop_front()) : 1'($urandom);
      step(e, b, r, s);
      check_model(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
